// File: rtl/if_fetch_buffer_pkg.sv
// Shared definitions for the instruction-fetch buffer: FSM state encodings and
// default address/data widths.
package if_fetch_buffer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;

endpackage

// File: rtl/if_fetch_buffer_fetch_fifo.sv
// Small FIFO of {instruction, pc} pairs with synchronous clear; head outputs
// read as zero while the FIFO is empty.
module fetch_fifo #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_instr,
  input  logic [ADDR_W-1:0]        push_pc,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output logic [DATA_W-1:0]        head_instr,
  output logic [ADDR_W-1:0]        head_pc
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W+ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W-1:0]         wr_ptr;
  logic                     do_pop;

  assign head_valid = (count != '0);
  assign do_pop     = pop && head_valid;
  assign {head_instr, head_pc} = head_valid ? mem[rd_ptr] : '0;

  // Storage is data only; its contents are never observed while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_instr, push_pc};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_buffer.sv
// Fetch stage: issues one outstanding imem request at a time, buffers returned
// words with their PC and hands them to decode; redirects discard everything.
module if_fetch_buffer
  import if_fetch_buffer_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              flush,
  output logic              pc_stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pcplus4
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  fetch_state_t   state;
  logic [PTR_W:0] count;
  logic           full;
  logic           push;
  logic           pop;

  // A request is only issued with a free slot, so a push can never overflow.
  assign full       = (count == FULL_CNT);
  assign pc_stall   = (state != S_IDLE) || flush || full;
  assign push       = (state == S_WAIT) && imem_ack && !flush;
  assign pop        = id_valid && id_ready;
  assign id_pcplus4 = id_pc + ADDR_W'(4);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= S_IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!flush && !full) begin
            imem_req  <= 1'b1;
            imem_addr <= pc_in;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= S_IDLE;
          end else if (flush) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The memory still owes a response; absorb it before re-issuing.
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear      (flush),
    .push       (push),
    .push_instr (imem_rdata),
    .push_pc    (imem_addr),
    .pop        (pop),
    .count      (count),
    .head_valid (id_valid),
    .head_instr (id_instr),
    .head_pc    (id_pc)
  );

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed bench for if_fetch_buffer: cycle table for streaming/backpressure,
// hand sequences for flush, reset and address wrap.
module tb_if_fetch_buffer;

  logic        clk;
  logic        n_rst;
  logic [31:0] pc_in;
  logic        flush;
  logic        pc_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pcplus4;

  int checks = 0;
  int errors = 0;
  int bad_seen = 0;

  if_fetch_buffer #(.DEPTH(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .pc_in      (pc_in),
    .flush      (flush),
    .pc_stall   (pc_stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_pcplus4 (id_pcplus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Discarded words must never reach decode.
  always @(negedge clk) begin
    if (id_valid && (id_instr == 32'hDEADBEEF || id_instr == 32'hBADBAD00))
      bad_seen++;
  end

  typedef struct {
    logic [31:0] pc;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        e_stall;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_p4;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    n_rst = 1'b0;
    pc_in = '0; flush = 1'b0; imem_ack = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  initial begin
    n_rst = 1'b1;
    pc_in = '0; flush = 1'b0; imem_ack = 1'b0; imem_rdata = '0; id_ready = 1'b0;

    //            pc       ack rdata         rdy stl req addr     vld instr         pc      pc+4
    tbl[0]  = '{32'h0,  1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,        32'h0, 32'h0};
    tbl[1]  = '{32'h4,  1'b1, 32'h20080005, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0,        32'h0, 32'h0};
    tbl[2]  = '{32'h4,  1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20080005, 32'h0, 32'h4};
    tbl[3]  = '{32'h8,  1'b1, 32'h00000013, 1'b1, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0,        32'h0, 32'h0};
    tbl[4]  = '{32'h8,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00000013, 32'h4, 32'h8};
    tbl[5]  = '{32'hC,  1'b1, 32'hAAAA0001, 1'b0, 1'b1, 1'b1, 32'h8, 1'b1, 32'h00000013, 32'h4, 32'h8};
    tbl[6]  = '{32'hC,  1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00000013, 32'h4, 32'h8};
    tbl[7]  = '{32'hC,  1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00000013, 32'h4, 32'h8};
    tbl[8]  = '{32'hC,  1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00000013, 32'h4, 32'h8};
    tbl[9]  = '{32'hC,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hAAAA0001, 32'h8, 32'hC};
    tbl[10] = '{32'h10, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hC, 1'b1, 32'hAAAA0001, 32'h8, 32'hC};
    tbl[11] = '{32'h10, 1'b1, 32'h12345678, 1'b1, 1'b1, 1'b1, 32'hC, 1'b0, 32'h0,        32'h0, 32'h0};
    tbl[12] = '{32'h10, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h12345678, 32'hC, 32'h10};

    // Reset values while n_rst is held low
    #3;
    n_rst = 1'b0;
    #1;
    chk("rst_stall", 0, pc_stall, 0);
    chk("rst_req",   0, imem_req, 0);
    chk("rst_addr",  0, imem_addr, 0);
    chk("rst_valid", 0, id_valid, 0);
    chk("rst_instr", 0, id_instr, 0);
    chk("rst_pc",    0, id_pc, 0);
    reset_dut();

    // Streaming, backpressure to full, ordered release
    for (int i = 0; i < 13; i++) begin
      pc_in = tbl[i].pc; imem_ack = tbl[i].ack; imem_rdata = tbl[i].rdata; id_ready = tbl[i].ready;
      #1;
      chk("stall", i, pc_stall, tbl[i].e_stall);
      chk("req",   i, imem_req, tbl[i].e_req);
      if (tbl[i].e_req) chk("addr", i, imem_addr, tbl[i].e_addr);
      chk("valid", i, id_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        chk("instr",  i, id_instr, tbl[i].e_instr);
        chk("id_pc",  i, id_pc, tbl[i].e_pc);
        chk("pcplus4", i, id_pcplus4, tbl[i].e_p4);
      end
      tick();
    end

    // Flush while waiting; response arrives 3 cycles later and is dropped
    reset_dut();
    id_ready = 1'b1;
    pc_in = 32'h100;
    tick();
    flush = 1'b1; pc_in = 32'h00400020;
    #1; chk("fl_stall", 0, pc_stall, 1);
    tick();
    flush = 1'b0;
    #1;
    chk("drain_req",   0, imem_req, 1);
    chk("drain_addr",  0, imem_addr, 32'h100);
    chk("drain_stall", 0, pc_stall, 1);
    tick();
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    #1; chk("drain_stall", 1, pc_stall, 1);
    tick();
    imem_ack = 1'b0;
    #1;
    chk("post_drain_stall", 0, pc_stall, 0);
    chk("post_drain_valid", 0, id_valid, 0);
    tick();
    chk("redir_req",  0, imem_req, 1);
    chk("redir_addr", 0, imem_addr, 32'h00400020);
    imem_ack = 1'b1; imem_rdata = 32'h11111111;
    tick();
    imem_ack = 1'b0;
    #1;
    chk("redir_valid", 0, id_valid, 1);
    chk("redir_instr", 0, id_instr, 32'h11111111);
    chk("redir_pc",    0, id_pc, 32'h00400020);

    // Flush coincident with ack, with an older entry buffered
    tick();
    id_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h22222222;
    tick();
    imem_ack = 1'b0; pc_in = 32'h204;
    #1; chk("pre_flush_instr", 0, id_instr, 32'h22222222);
    tick();
    flush = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBADBAD00;
    #1; chk("flack_stall", 0, pc_stall, 1);
    tick();
    flush = 1'b0; imem_ack = 1'b0; pc_in = 32'h300;
    #1;
    chk("flack_valid", 0, id_valid, 0);
    chk("flack_req",   0, imem_req, 0);
    chk("flack_stall", 1, pc_stall, 0);
    tick();
    chk("flack_req",   1, imem_req, 1);
    chk("flack_addr",  0, imem_addr, 32'h300);
    chk("flack_valid", 1, id_valid, 0);
    imem_ack = 1'b1; imem_rdata = 32'h33333333;
    tick();
    imem_ack = 1'b0;
    #1;
    chk("after_flack_instr", 0, id_instr, 32'h33333333);
    chk("after_flack_pc",    0, id_pc, 32'h300);

    // Asynchronous reset mid-WAIT, then a stray ack in IDLE
    pc_in = 32'h400;
    tick();
    chk("pre_rst_req", 0, imem_req, 1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_req",   0, imem_req, 0);
    chk("arst_addr",  0, imem_addr, 0);
    chk("arst_valid", 0, id_valid, 0);
    chk("arst_instr", 0, id_instr, 0);
    chk("arst_pc",    0, id_pc, 0);
    chk("arst_stall", 0, pc_stall, 0);
    tick();
    n_rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h44444444; pc_in = 32'h500;
    tick();
    imem_ack = 1'b0;
    #1;
    chk("stray_valid", 0, id_valid, 0);
    chk("stray_req",   0, imem_req, 1);
    chk("stray_addr",  0, imem_addr, 32'h500);

    // PC+4 wrap at the top of the address space
    id_ready = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h55555555;
    tick();
    imem_ack = 1'b0; pc_in = 32'hFFFFFFFC;
    #1;
    chk("p500_pc", 0, id_pc, 32'h500);
    chk("p500_p4", 0, id_pcplus4, 32'h504);
    tick();
    chk("wrap_addr", 0, imem_addr, 32'hFFFFFFFC);
    imem_ack = 1'b1; imem_rdata = 32'h66666666;
    tick();
    imem_ack = 1'b0;
    #1;
    chk("wrap_valid", 0, id_valid, 1);
    chk("wrap_instr", 0, id_instr, 32'h66666666);
    chk("wrap_pc",    0, id_pc, 32'hFFFFFFFC);
    chk("wrap_p4",    0, id_pcplus4, 32'h0);

    chk("no_discarded_on_id", 0, bad_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
